// File: rtl/sha_miner_avmm_slave.sv
`default_nettype none
// ============================================================================
// Module      : sha_miner_avmm_slave
// Description : Avalon-MM responder holding one SHA-256 mining job. It sweeps
//               a nonce range through an external SHA-256 core over a
//               start/done handshake and reports found/exhausted status.
//               Optional interrupt output enabled by macro SHA_MINER_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_miner_avmm_slave #(
  parameter int NONCE_W = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  output logic               sha_start,
  output logic [255:0]       sha_midstate,
  output logic [95:0]        sha_tail,
  output logic [NONCE_W-1:0] sha_nonce,
  input  logic               sha_done,
  input  logic [255:0]       sha_hash
`ifdef SHA_MINER_IRQ_EN
  ,
  output logic               irq
`endif
);

  // Word addresses of the register map
  localparam logic [ADDR_W-1:0] A_MID7   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_TAIL0  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_TAIL1  = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] A_TAIL2  = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] A_TARGET = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] A_NSTART = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] A_NEND   = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(15);
  localparam logic [ADDR_W-1:0] A_FNONCE = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] A_CNONCE = ADDR_W'(17);
  localparam logic [ADDR_W-1:0] A_HCOUNT = ADDR_W'(18);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t             state_q;
  logic [31:0]        midstate_q [8];
  logic [31:0]        tail_q [3];
  logic [31:0]        target_q;
  logic [NONCE_W-1:0] nonce_start_q;
  logic [NONCE_W-1:0] nonce_end_q;
  logic [NONCE_W-1:0] cur_nonce_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic [NONCE_W-1:0] hash_count_q;
  logic [31:0]        hash_top_q;
  logic               found_q, found_d;
  logic               exhausted_q, exhausted_d;
  logic               sha_start_q;
  logic [31:0]        readdata_q, readdata_d;

  logic busy;
  logic ctrl_wr;
  logic abort_req;
  logic start_req;
  logic hit;
  logic unused_hash_low;

  assign busy      = (state_q != S_IDLE);
  assign ctrl_wr   = avs_write && (avs_address == A_CTRL);
  // Abort dominates a simultaneous start; start is only honoured when idle
  assign abort_req = ctrl_wr && avs_writedata[1];
  assign start_req = ctrl_wr && avs_writedata[0] && !avs_writedata[1] && !busy;
  assign hit       = (hash_top_q <= target_q);

  // Only the top word of the digest takes part in the target comparison
  assign unused_hash_low = ^sha_hash[223:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_midstate
      assign sha_midstate[gi*32 +: 32] = midstate_q[gi];
    end
  endgenerate

  assign sha_tail     = {tail_q[2], tail_q[1], tail_q[0]};
  assign sha_nonce    = cur_nonce_q;
  assign sha_start    = sha_start_q;
  assign avs_readdata = readdata_q;

`ifdef SHA_MINER_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q;
  logic status_wr;

  assign status_wr = avs_write && (avs_address == A_STATUS);
  assign irq_en_d  = ctrl_wr ? avs_writedata[2] : irq_en_q;
  assign irq       = irq_q;

  // Interrupt enable and level interrupt, aligned with the sticky status bits
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_d & (found_d | exhausted_d);
    end
  end
`endif

  // Next value of the sticky found/exhausted flags
  always_comb begin
    found_d     = found_q;
    exhausted_d = exhausted_q;
`ifdef SHA_MINER_IRQ_EN
    if (status_wr) begin
      found_d     = 1'b0;
      exhausted_d = 1'b0;
    end
`endif
    if (start_req) begin
      found_d     = 1'b0;
      exhausted_d = 1'b0;
    end
    if (state_q == S_CHECK && !abort_req) begin
      if (hit) begin
        found_d = 1'b1;
      end else if (cur_nonce_q == nonce_end_q) begin
        exhausted_d = 1'b1;
      end
    end
  end

  // Job configuration registers, frozen while a sweep is running
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) midstate_q[i] <= '0;
      for (int i = 0; i < 3; i++) tail_q[i] <= '0;
      target_q      <= '0;
      nonce_start_q <= '0;
      nonce_end_q   <= '0;
    end else if (avs_write && !busy) begin
      if (avs_address <= A_MID7) begin
        midstate_q[avs_address[2:0]] <= avs_writedata;
      end else begin
        case (avs_address)
          A_TAIL0:  tail_q[0]     <= avs_writedata;
          A_TAIL1:  tail_q[1]     <= avs_writedata;
          A_TAIL2:  tail_q[2]     <= avs_writedata;
          A_TARGET: target_q      <= avs_writedata;
          A_NSTART: nonce_start_q <= NONCE_W'(avs_writedata);
          A_NEND:   nonce_end_q   <= NONCE_W'(avs_writedata);
          default:  ;
        endcase
      end
    end
  end

  // Sweep controller: issue a hash, wait for it, compare, advance
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sha_start_q   <= 1'b0;
      cur_nonce_q   <= '0;
      found_nonce_q <= '0;
      hash_count_q  <= '0;
      hash_top_q    <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      sha_start_q <= 1'b0;
      if (abort_req) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_req) begin
              cur_nonce_q  <= nonce_start_q;
              hash_count_q <= '0;
              sha_start_q  <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (sha_done) begin
              hash_top_q   <= sha_hash[255:224];
              hash_count_q <= hash_count_q + NONCE_W'(1);
              state_q      <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (hit) begin
              found_nonce_q <= cur_nonce_q;
              state_q       <= S_IDLE;
            end else if (cur_nonce_q == nonce_end_q) begin
              state_q <= S_IDLE;
            end else begin
              cur_nonce_q <= cur_nonce_q + NONCE_W'(1);
              sha_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Read data multiplexer
  always_comb begin
    readdata_d = '0;
    if (avs_address <= A_MID7) begin
      readdata_d = midstate_q[avs_address[2:0]];
    end else begin
      case (avs_address)
        A_TAIL0:  readdata_d = tail_q[0];
        A_TAIL1:  readdata_d = tail_q[1];
        A_TAIL2:  readdata_d = tail_q[2];
        A_TARGET: readdata_d = target_q;
        A_NSTART: readdata_d = 32'(nonce_start_q);
        A_NEND:   readdata_d = 32'(nonce_end_q);
`ifdef SHA_MINER_IRQ_EN
        A_CTRL:   readdata_d = {29'd0, irq_en_q, 2'b00};
`endif
        A_STATUS: readdata_d = {29'd0, exhausted_q, found_q, busy};
        A_FNONCE: readdata_d = 32'(found_nonce_q);
        A_CNONCE: readdata_d = 32'(cur_nonce_q);
        A_HCOUNT: readdata_d = 32'(hash_count_q);
        default:  readdata_d = '0;
      endcase
    end
  end

  // Fixed one-cycle read latency; idle cycles return zero
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= avs_read ? readdata_d : 32'd0;
    end
  end

endmodule
`default_nettype wire
